ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares one single-port RAM port (en/we/addr/wdata/rdata, 1-cycle read latency) between two requesters: requester 0 (CPU) and requester 1 (SPI slave/DMA side).
- Accepts one request at a time through a req/gnt handshake, drives the RAM with registered signals, and returns read data with a one-cycle rvalid pulse.
- Sits between the CPU/SPI front ends and the RAM's MEM-side port.

Parameters:
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 32, RAM data width.
- FIXED_PRIO, 0. 0 = round-robin on ties; 1 = requester 0 always wins ties.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0 / req1  input  1  access request; held high until the matching gnt pulse.
- we0 / we1  input  1  1 = write, 0 = read; held with req.
- addr0 / addr1  input  ADDR_WIDTH  word address; held with req.
- wdata0 / wdata1  input  DATA_WIDTH  write data; held with req.
- gnt0 / gnt1  output  1  one-cycle pulse: request accepted (command latched).
- rvalid0 / rvalid1  output  1  one-cycle pulse: rdata0/rdata1 valid.
- rdata0 / rdata1  output  DATA_WIDTH  read data; holds its last value between pulses.
- mem_en  output  1  RAM enable.
- mem_we  output  1  RAM write enable.
- mem_addr  output  ADDR_WIDTH  RAM address.
- mem_wdata  output  DATA_WIDTH  RAM write data.
- mem_rdata  input  DATA_WIDTH  RAM read data; valid the cycle after an en=1, we=0 cycle.
- busy  output  1  1 whenever state != IDLE.

Behaviour:
- All outputs are registered. Reset values: gnt*, rvalid*, mem_en, mem_we, busy = 0; mem_addr, mem_wdata, rdata* = 0. Reset sets state = IDLE and last_owner = 1.

State machine: IDLE, ISSUE, RWAIT.
- IDLE: if any req, pick the winner, then at the next edge:
  - latch we/addr/wdata into the mem_* registers;
  - set owner = winner and last_owner = winner;
  - pulse gnt[owner];
  - go to ISSUE with mem_en = 1.
  - No req: stay in IDLE with mem_en = 0.
- ISSUE: mem_en = 1 for exactly this cycle.
  - Write: at the next edge, mem_en = 0 and go to IDLE.
  - Read: at the next edge, mem_en = 0 and go to RWAIT.
- RWAIT: mem_rdata is valid. At the next edge:
  - rdata[owner] <= mem_rdata;
  - pulse rvalid[owner];
  - go to IDLE.
- While in IDLE, mem_we, mem_addr and mem_wdata hold their last values.

Winner selection:
- Single requester: that requester wins.
- Both requesting, FIXED_PRIO = 1: requester 0 wins.
- Both requesting, FIXED_PRIO = 0: !last_owner wins, so requester 0 wins the first tie after reset.

Latency and throughput:
- Write: req sampled at cycle T; gnt and mem_en=1 at T+1; back in IDLE at T+2. Two cycles per write.
- Read: same as write up to T+1; RWAIT at T+2; rvalid and rdata at T+3; IDLE at T+3. Three cycles per read.
- Back-to-back: a req still high in the IDLE cycle is accepted at the next edge.

Handshake rules:
- Requesters drop req in the cycle gnt is high or later. req is not sampled outside IDLE, so a req held high through gnt is not double-accepted.
- A requester may issue a new req before its rvalid arrives. That request is queued behind the RWAIT state.
- Command inputs may change freely once gnt has been seen.

Boundary conditions:
- req deasserted before gnt (protocol violation): no access if dropped before IDLE samples it; undefined otherwise.
- rst asserted in any state: IDLE next edge, mem_en = 0, no gnt or rvalid. An in-flight write may or may not have committed; an in-flight read is discarded.
- Address 0 and address 2^ADDR_WIDTH-1 are handled with no special casing.

Decomposition:
- Package ram_arb_pkg contains:
  - state_t enum {IDLE, ISSUE, RWAIT};
  - typedef req_id_t (1 bit);
  - localparams REQ_CPU = 0 and REQ_SPI = 1.
- Sub-module ram_arb_rr_picker (combinational): inputs req0, req1, last_owner, FIXED_PRIO; outputs winner and any_req.
- The FSM and datapath live in ram_port_arbiter.

Test Plan:
- Single write: req0 with we=1, addr=0x10, wdata=0xDEADBEEF → gnt0 at T+1; mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF for exactly 1 cycle; busy low at T+2.
- Read-back: req1 read of addr 0x10, RAM model returns 0xDEADBEEF → gnt1 at T+1, rvalid1 at T+3 with rdata1=0xDEADBEEF; rvalid0 stays 0.
- Tie, FIXED_PRIO=0, both requesting reads held continuously for 4 grants → grant order 0,1,0,1; each rvalid goes only to its owner.
- Tie, FIXED_PRIO=1 → requester 0 granted every time while req0 is held; requester 1 is granted only once req0 drops.
- Reset mid-read: rst asserted in the ISSUE cycle of a read → next cycle state IDLE, mem_en=0, no rvalid ever appears; a subsequent req0 write to 0xFF completes normally.
- Back-to-back writes from requester 0 to addresses 0x00 and 0xFF (req0 re-asserted in the IDLE cycle) → gnt0 pulses 2 cycles apart; the RAM model contains both values.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM port arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT} state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_CPU = 1'b0;
  localparam req_id_t REQ_SPI = 1'b1;

endpackage

// File: rtl/ram_arb_rr_picker.sv
// Combinational winner selection between the CPU and SPI requesters.
module ram_arb_rr_picker
  import ram_arb_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic    req0,
  input  logic    req1,
  input  req_id_t last_owner,
  output req_id_t winner,
  output logic    any_req
);

  // Lone requester wins; ties go to CPU or alternate away from the last owner.
  always_comb begin
    any_req = req0 | req1;
    winner  = REQ_CPU;
    if (req0 && req1) begin
      winner = (FIXED_PRIO != 0) ? REQ_CPU : req_id_t'(~last_owner);
    end else if (req1) begin
      winner = REQ_SPI;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between two requesters; one access in flight at a time.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  state_t                state_q, state_d;
  req_id_t               owner_q, owner_d;
  req_id_t               last_owner_q, last_owner_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  busy_q, busy_d;

  req_id_t winner;
  logic    any_req;

  ram_arb_rr_picker #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_picker (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  // Next-state logic: accept in IDLE, strobe RAM in ISSUE, capture read data in RWAIT.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    gnt_d        = '0;
    rvalid_d     = '0;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d       = ISSUE;
          owner_d       = winner;
          last_owner_d  = winner;
          gnt_d[winner] = 1'b1;
          mem_en_d      = 1'b1;
          if (winner == REQ_SPI) begin
            mem_we_d    = we1;
            mem_addr_d  = addr1;
            mem_wdata_d = wdata1;
          end else begin
            mem_we_d    = we0;
            mem_addr_d  = addr0;
            mem_wdata_d = wdata0;
          end
        end
      end
      ISSUE: begin
        state_d = mem_we_q ? IDLE : RWAIT;
      end
      RWAIT: begin
        state_d           = IDLE;
        rvalid_d[owner_q] = 1'b1;
        if (owner_q == REQ_SPI) begin
          rdata1_d = mem_rdata;
        end else begin
          rdata0_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
    // busy is registered, so it tracks the state being entered.
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= REQ_CPU;
      last_owner_q <= REQ_SPI;
      gnt_q        <= '0;
      rvalid_q     <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      gnt_q        <= gnt_d;
      rvalid_q     <= rvalid_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt0      = gnt_q[0];
  assign gnt1      = gnt_q[1];
  assign rvalid0   = rvalid_q[0];
  assign rvalid1   = rvalid_q[1];
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench: two arbiter instances (round-robin and fixed priority), each with its own RAM model.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req    [2][2];
  logic        we     [2][2];
  logic [7:0]  addr   [2][2];
  logic [31:0] wdata  [2][2];
  logic        gnt    [2][2];
  logic        rvalid [2][2];
  logic [31:0] rdata  [2][2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [7:0]  mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];

  bit [31:0] ram   [2][256];
  bit [31:0] model [2][256];
  bit        lo    [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ram_port_arbiter #(
      .ADDR_WIDTH (8),
      .DATA_WIDTH (32),
      .FIXED_PRIO (g)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req[g][0]),
      .we0       (we[g][0]),
      .addr0     (addr[g][0]),
      .wdata0    (wdata[g][0]),
      .req1      (req[g][1]),
      .we1       (we[g][1]),
      .addr1     (addr[g][1]),
      .wdata1    (wdata[g][1]),
      .gnt0      (gnt[g][0]),
      .gnt1      (gnt[g][1]),
      .rvalid0   (rvalid[g][0]),
      .rvalid1   (rvalid[g][1]),
      .rdata0    (rdata[g][0]),
      .rdata1    (rdata[g][1]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g])
    );

    // Single-port RAM with one-cycle read latency.
    always @(posedge clk) begin
      if (mem_en[g]) begin
        if (mem_we[g]) ram[g][mem_addr[g]] <= mem_wdata[g];
        else           mem_rdata[g] <= ram[g][mem_addr[g]];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance until either grant of instance d pulses, bounded.
  task automatic wait_gnt(input int d);
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (gnt[d][0] === 1'b1 || gnt[d][1] === 1'b1) seen = 1'b1;
    end
    chk1("gnt_within_bound", seen, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 2; r++) begin
        req[d][r] = 1'b0; we[d][r] = 1'b0; addr[d][r] = '0; wdata[d][r] = '0;
      end
      lo[d] = 1'b1;
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One random round: one or both requesters issue; order follows the arbitration rules.
  task automatic rand_round(input int d);
    int  pat = $urandom_range(1, 3);
    bit  pend [2];
    int  w;
    for (int r = 0; r < 2; r++) begin
      pend[r] = pat[r];
      if (pend[r]) begin
        req[d][r]   = 1'b1;
        we[d][r]    = 1'($urandom_range(0, 1));
        addr[d][r]  = 8'($urandom);
        wdata[d][r] = $urandom;
      end
    end
    while (pend[0] || pend[1]) begin
      if (pend[0] && pend[1]) w = (d == 1) ? 0 : int'(!lo[d]);
      else                    w = pend[1] ? 1 : 0;
      wait_gnt(d);
      chk1("rand_gnt_winner", gnt[d][w], 1'b1);
      chk1("rand_gnt_loser", gnt[d][1-w], 1'b0);
      chk32("rand_mem_addr", 32'(mem_addr[d]), 32'(addr[d][w]));
      chk1("rand_mem_we", mem_we[d], we[d][w]);
      lo[d]     = w[0];
      pend[w]   = 1'b0;
      req[d][w] = 1'b0;
      if (we[d][w]) begin
        chk32("rand_mem_wdata", mem_wdata[d], wdata[d][w]);
        model[d][addr[d][w]] = wdata[d][w];
        tick();
      end else begin
        tick();
        tick();
        chk1("rand_rvalid_owner", rvalid[d][w], 1'b1);
        chk1("rand_rvalid_other", rvalid[d][1-w], 1'b0);
        chk32("rand_rdata", rdata[d][w], model[d][addr[d][w]]);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Reset state.
    chk1("rst_gnt0", gnt[0][0], 1'b0);
    chk1("rst_gnt1", gnt[0][1], 1'b0);
    chk1("rst_rvalid0", rvalid[0][0], 1'b0);
    chk1("rst_mem_en", mem_en[0], 1'b0);
    chk1("rst_mem_we", mem_we[0], 1'b0);
    chk1("rst_busy", busy[0], 1'b0);
    chk32("rst_mem_addr", 32'(mem_addr[0]), 32'h0);
    chk32("rst_mem_wdata", mem_wdata[0], 32'h0);
    chk32("rst_rdata0", rdata[0][0], 32'h0);
    chk32("rst_rdata1", rdata[0][1], 32'h0);

    // Single write from requester 0.
    req[0][0] = 1'b1; we[0][0] = 1'b1; addr[0][0] = 8'h10; wdata[0][0] = 32'hDEADBEEF;
    tick();
    chk1("wr_gnt0", gnt[0][0], 1'b1);
    chk1("wr_gnt1", gnt[0][1], 1'b0);
    chk1("wr_mem_en", mem_en[0], 1'b1);
    chk1("wr_mem_we", mem_we[0], 1'b1);
    chk32("wr_mem_addr", 32'(mem_addr[0]), 32'h10);
    chk32("wr_mem_wdata", mem_wdata[0], 32'hDEADBEEF);
    chk1("wr_busy_t1", busy[0], 1'b1);
    req[0][0] = 1'b0;
    model[0][8'h10] = 32'hDEADBEEF;
    tick();
    chk1("wr_mem_en_off", mem_en[0], 1'b0);
    chk1("wr_busy_t2", busy[0], 1'b0);
    chk1("wr_gnt0_off", gnt[0][0], 1'b0);
    chk32("wr_ram", ram[0][8'h10], 32'hDEADBEEF);

    // Read-back from requester 1.
    req[0][1] = 1'b1; we[0][1] = 1'b0; addr[0][1] = 8'h10;
    tick();
    chk1("rd_gnt1", gnt[0][1], 1'b1);
    chk1("rd_mem_en", mem_en[0], 1'b1);
    chk1("rd_mem_we", mem_we[0], 1'b0);
    req[0][1] = 1'b0;
    tick();
    chk1("rd_rvalid_early", rvalid[0][1], 1'b0);
    chk1("rd_busy_rwait", busy[0], 1'b1);
    tick();
    chk1("rd_rvalid1", rvalid[0][1], 1'b1);
    chk1("rd_rvalid0", rvalid[0][0], 1'b0);
    chk32("rd_rdata1", rdata[0][1], 32'hDEADBEEF);
    chk1("rd_busy_done", busy[0], 1'b0);

    // Round-robin tie: both reads held for four grants, expect 0,1,0,1.
    req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 8'h10;
    req[0][1] = 1'b1; we[0][1] = 1'b0; addr[0][1] = 8'h20;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(0);
      chk1("rr_gnt_owner", gnt[0][k%2], 1'b1);
      chk1("rr_gnt_other", gnt[0][1-(k%2)], 1'b0);
      if (k == 3) begin
        req[0][0] = 1'b0;
        req[0][1] = 1'b0;
      end
      tick();
      tick();
      chk1("rr_rvalid_owner", rvalid[0][k%2], 1'b1);
      chk1("rr_rvalid_other", rvalid[0][1-(k%2)], 1'b0);
      chk32("rr_rdata", rdata[0][k%2], model[0][addr[0][k%2]]);
    end

    // Fixed priority on instance 1: requester 0 keeps winning until it drops.
    req[1][0] = 1'b1; we[1][0] = 1'b0; addr[1][0] = 8'h30;
    req[1][1] = 1'b1; we[1][1] = 1'b0; addr[1][1] = 8'h40;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(1);
      chk1("fp_gnt0", gnt[1][0], 1'b1);
      chk1("fp_gnt1_blocked", gnt[1][1], 1'b0);
      if (k == 2) req[1][0] = 1'b0;
      tick();
      tick();
      chk1("fp_rvalid0", rvalid[1][0], 1'b1);
    end
    wait_gnt(1);
    chk1("fp_gnt1_late", gnt[1][1], 1'b1);
    chk1("fp_gnt0_dropped", gnt[1][0], 1'b0);
    req[1][1] = 1'b0;
    tick();
    tick();
    chk1("fp_rvalid1", rvalid[1][1], 1'b1);

    // Reset asserted in the ISSUE cycle of a read: no rvalid may follow.
    req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 8'h10;
    wait_gnt(0);
    chk1("mr_issue_en", mem_en[0], 1'b1);
    rst = 1'b1;
    req[0][0] = 1'b0;
    tick();
    chk1("mr_mem_en", mem_en[0], 1'b0);
    chk1("mr_busy", busy[0], 1'b0);
    chk1("mr_gnt0", gnt[0][0], 1'b0);
    chk1("mr_rvalid0", rvalid[0][0], 1'b0);
    rst = 1'b0;
    lo[0] = 1'b1;
    lo[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("mr_no_rvalid", rvalid[0][0] | rvalid[0][1], 1'b0);
    end
    req[0][0] = 1'b1; we[0][0] = 1'b1; addr[0][0] = 8'hFF; wdata[0][0] = 32'hA5A50FF0;
    wait_gnt(0);
    chk1("mr_wr_gnt0", gnt[0][0], 1'b1);
    req[0][0] = 1'b0;
    tick();
    chk1("mr_wr_busy", busy[0], 1'b0);
    chk32("mr_wr_ram", ram[0][8'hFF], 32'hA5A50FF0);

    // Back-to-back writes to the address extremes.
    req[0][0] = 1'b1; we[0][0] = 1'b1; addr[0][0] = 8'h00; wdata[0][0] = 32'h11110000;
    wait_gnt(0);
    chk1("bb_gnt_first", gnt[0][0], 1'b1);
    chk32("bb_addr_first", 32'(mem_addr[0]), 32'h00);
    addr[0][0] = 8'hFF; wdata[0][0] = 32'h2222FFFF;
    tick();
    chk1("bb_gnt_gap", gnt[0][0], 1'b0);
    chk1("bb_busy_gap", busy[0], 1'b0);
    tick();
    chk1("bb_gnt_second", gnt[0][0], 1'b1);
    chk32("bb_addr_second", 32'(mem_addr[0]), 32'hFF);
    req[0][0] = 1'b0;
    tick();
    chk32("bb_ram_lo", ram[0][8'h00], 32'h11110000);
    chk32("bb_ram_hi", ram[0][8'hFF], 32'h2222FFFF);
    model[0][8'h00] = 32'h11110000;
    model[0][8'hFF] = 32'h2222FFFF;

    // Randomized rounds on both instances from a clean reset.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      rand_round(0);
      rand_round(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
